// File: rtl/audio_rec_pkg.sv
// Shared types and default constants for the audio record/playback sequencer.
package audio_rec_pkg;

  // Sequencer state, encoded as seen on the state output.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REC  = 2'd1,
    ST_PLAY = 2'd2
  } state_t;

  // 100 MHz system clock, 8 kHz sample rate, 128 Ki x 8-bit sample memory.
  localparam int DIV_DEF    = 12500;
  localparam int ADDR_W_DEF = 17;
  localparam int DATA_W_DEF = 8;

endpackage

// File: rtl/audio_rec_ctrl_sample_tick_gen.sv
// sample_tick_gen: free-running 0..DIV-1 counter producing a one-cycle tick
// at count DIV-1. clr_i or a low en_i hold the count at 0.
module sample_tick_gen
  import audio_rec_pkg::*;
#(
  parameter int DIV = DIV_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: hold at zero when cleared or idle, otherwise wrap at DIV-1.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || !en_i) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = en_i && !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/audio_rec_ctrl.sv
// audio_rec_ctrl: record/playback sequencer owning the single sample-memory
// port. Records mic samples at one per DIV cycles, replays them to PWM.
// Optional feature macro: AUDIO_REC_LOOP_EN (looped playback until stop_req).
module audio_rec_ctrl
  import audio_rec_pkg::*;
#(
  parameter int DIV    = DIV_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rec_req,
  input  logic              play_req,
  input  logic              stop_req,
  input  logic [DATA_W-1:0] mic_sample,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] play_sample,
  output logic [1:0]        state,
  output logic [ADDR_W:0]   rec_len
);

  localparam int LEN_W = ADDR_W + 1;
  localparam logic [LEN_W-1:0] FULL_LEN = {1'b1, {ADDR_W{1'b0}}};

  state_t              state_q;
  logic [ADDR_W-1:0]   wr_ptr_q;
  logic [ADDR_W-1:0]   rd_ptr_q;
  logic [LEN_W-1:0]    rec_len_q;
  logic [DATA_W-1:0]   play_q;
  logic                tick;
  logic                last_rd;

  // The counter idles at zero, so entering REC/PLAY always starts a fresh period.
  sample_tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (state_q == ST_IDLE),
    .en_i   (state_q != ST_IDLE),
    .tick_o (tick)
  );

  assign last_rd = ({1'b0, rd_ptr_q} == (rec_len_q - LEN_W'(1)));

  // Sequencer: request arbitration, pointer advance, length capture, playback sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rec_len_q <= '0;
      play_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rec_req) begin
            state_q  <= ST_REC;
            wr_ptr_q <= '0;
          end else if (play_req && (rec_len_q != '0)) begin
            state_q  <= ST_PLAY;
            rd_ptr_q <= '0;
          end
        end
        ST_REC: begin
          // A tick in the same cycle as stop_req is dropped, not written.
          if (stop_req) begin
            state_q   <= ST_IDLE;
            rec_len_q <= {1'b0, wr_ptr_q};
          end else if (tick) begin
            wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
            if (wr_ptr_q == {ADDR_W{1'b1}}) begin
              state_q   <= ST_IDLE;
              rec_len_q <= FULL_LEN;
            end
          end
        end
        ST_PLAY: begin
          if (stop_req) begin
            state_q <= ST_IDLE;
          end else if (tick) begin
            play_q <= mem_rdata;
            if (last_rd) begin
`ifdef AUDIO_REC_LOOP_EN
              rd_ptr_q <= '0;
`else
              state_q  <= ST_IDLE;
`endif
            end else begin
              rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Memory port: address follows the active pointer; the write strobe is the
  // REC tick itself so data and strobe land in the same cycle.
  always_comb begin
    mem_addr = '0;
    case (state_q)
      ST_REC:  mem_addr = wr_ptr_q;
      ST_PLAY: mem_addr = rd_ptr_q;
      default: mem_addr = '0;
    endcase
    mem_we    = (state_q == ST_REC) && tick && !stop_req;
    mem_wdata = mem_we ? mic_sample : '0;
  end

  assign play_sample = play_q;
  assign state       = state_q;
  assign rec_len     = rec_len_q;

endmodule

// File: tb/tb_audio_rec_ctrl.sv
// Directed bench for audio_rec_ctrl with DIV=4, ADDR_W=3, DATA_W=8 and a
// small synchronous-read memory model. Honours AUDIO_REC_LOOP_EN if defined.
module tb_audio_rec_ctrl;

  localparam int DIV    = 4;
  localparam int ADDR_W = 3;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              rec_req = 1'b0;
  logic              play_req = 1'b0;
  logic              stop_req = 1'b0;
  logic [DATA_W-1:0] mic_sample = '0;
  logic [DATA_W-1:0] mem_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] play_sample;
  logic [1:0]        state;
  logic [ADDR_W:0]   rec_len;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_W-1:0] mem [1<<ADDR_W];

  audio_rec_ctrl #(
    .DIV    (DIV),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rec_req     (rec_req),
    .play_req    (play_req),
    .stop_req    (stop_req),
    .mic_sample  (mic_sample),
    .mem_rdata   (mem_rdata),
    .mem_addr    (mem_addr),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .play_sample (play_sample),
    .state       (state),
    .rec_len     (rec_len)
  );

  always #5 clk = ~clk;

  // Block RAM model: write-enable plus one-cycle synchronous read.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", state); end
    n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_we got=%0b exp=0", mem_we); end
    n_checks++; if (play_sample !== 8'd0) begin n_fail++; $display("FAIL reset_play got=%0d exp=0", play_sample); end
    n_checks++; if (rec_len !== 4'd0) begin n_fail++; $display("FAIL reset_len got=%0d exp=0", rec_len); end
    n_checks++; if (mem_addr !== 3'd0) begin n_fail++; $display("FAIL reset_addr got=%0d exp=0", mem_addr); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_play_empty();
    play_req = 1'b1;
    step();
    play_req = 1'b0;
    n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL play_empty_state got=%0d exp=0", state); end
    step();
  endtask

  task automatic test_fill();
    int wr_cnt = 0;
    rec_req = 1'b1;
    step();
    rec_req = 1'b0;
    n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL fill_enter got=%0d exp=1", state); end
    for (int c = 0; c < 40; c++) begin
      mic_sample = 8'(wr_cnt + 1);
      #1;
      if (mem_we === 1'b1) begin
        n_checks++; if (c !== 3 + 4 * wr_cnt) begin n_fail++; $display("FAIL fill_cycle got=%0d exp=%0d", c, 3 + 4 * wr_cnt); end
        n_checks++; if (mem_addr !== 3'(wr_cnt)) begin n_fail++; $display("FAIL fill_addr got=%0d exp=%0d", mem_addr, wr_cnt); end
        n_checks++; if (mem_wdata !== 8'(wr_cnt + 1)) begin n_fail++; $display("FAIL fill_data got=%0d exp=%0d", mem_wdata, wr_cnt + 1); end
        wr_cnt++;
      end
      step();
    end
    n_checks++; if (wr_cnt !== 8) begin n_fail++; $display("FAIL fill_count got=%0d exp=8", wr_cnt); end
    n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL fill_idle got=%0d exp=0", state); end
    n_checks++; if (rec_len !== 4'd8) begin n_fail++; $display("FAIL fill_len got=%0d exp=8", rec_len); end
  endtask

  task automatic test_playback();
    int exp_ps;
    int exp_st;
    logic [DATA_W-1:0] hold;
    play_req = 1'b1;
    step();
    play_req = 1'b0;
    for (int c = 0; c < 40; c++) begin
`ifdef AUDIO_REC_LOOP_EN
      exp_ps = (c < 4) ? 0 : ((c / 4 - 1) % 8) + 1;
      exp_st = 2;
`else
      exp_ps = (c < 32) ? c / 4 : 8;
      exp_st = (c < 32) ? 2 : 0;
`endif
      n_checks++; if (play_sample !== 8'(exp_ps)) begin n_fail++; $display("FAIL play_sample c=%0d got=%0d exp=%0d", c, play_sample, exp_ps); end
      n_checks++; if (state !== 2'(exp_st)) begin n_fail++; $display("FAIL play_state c=%0d got=%0d exp=%0d", c, state, exp_st); end
      step();
    end
    hold = play_sample;
    stop_req = 1'b1;
    step();
    stop_req = 1'b0;
    n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL play_stop_state got=%0d exp=0", state); end
    n_checks++; if (play_sample !== hold) begin n_fail++; $display("FAIL play_hold got=%0d exp=%0d", play_sample, hold); end
  endtask

  task automatic test_rec_during_play();
    play_req = 1'b1;
    step();
    play_req = 1'b0;
    rec_req = 1'b1;
    for (int c = 0; c < 3; c++) begin
      n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL rec_in_play_state got=%0d exp=2", state); end
      n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rec_in_play_we got=%0b exp=0", mem_we); end
      step();
    end
    rec_req = 1'b0;
    stop_req = 1'b1;
    step();
    stop_req = 1'b0;
    n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL rec_in_play_stop got=%0d exp=0", state); end
  endtask

  task automatic test_stop_record();
    int wr_cnt = 0;
    int c = 0;
    int extra = 0;
    rec_req = 1'b1;
    step();
    rec_req = 1'b0;
    n_checks++; if (rec_len !== 4'd8) begin n_fail++; $display("FAIL stop_rec_oldlen got=%0d exp=8", rec_len); end
    while (wr_cnt < 3 && c < 20) begin
      mic_sample = 8'(8'h40 + wr_cnt);
      #1;
      if (mem_we === 1'b1) wr_cnt++;
      step();
      c++;
    end
    n_checks++; if (wr_cnt !== 3) begin n_fail++; $display("FAIL stop_rec_writes got=%0d exp=3", wr_cnt); end
    step();
    step();
    step();
    // Cycle of the 4th tick: stop coincides with it, so nothing is written.
    stop_req = 1'b1;
    #1;
    n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL stop_rec_tick_we got=%0b exp=0", mem_we); end
    step();
    stop_req = 1'b0;
    n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL stop_rec_state got=%0d exp=0", state); end
    n_checks++; if (rec_len !== 4'd3) begin n_fail++; $display("FAIL stop_rec_len got=%0d exp=3", rec_len); end
    for (int k = 0; k < 8; k++) begin
      if (mem_we !== 1'b0) extra++;
      step();
    end
    n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL stop_rec_extra_we got=%0d exp=0", extra); end
  endtask

  task automatic test_reset_mid_play();
    play_req = 1'b1;
    step();
    play_req = 1'b0;
    repeat (6) step();
    n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL rst_play_pre got=%0d exp=2", state); end
    n_checks++; if (play_sample !== 8'h40) begin n_fail++; $display("FAIL rst_play_sample got=%0d exp=64", play_sample); end
    reset = 1'b1;
    step();
    n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL rst_play_state got=%0d exp=0", state); end
    n_checks++; if (rec_len !== 4'd0) begin n_fail++; $display("FAIL rst_play_len got=%0d exp=0", rec_len); end
    n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_play_we got=%0b exp=0", mem_we); end
    n_checks++; if (play_sample !== 8'd0) begin n_fail++; $display("FAIL rst_play_ps got=%0d exp=0", play_sample); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_collision();
    play_req = 1'b1;
    step();
    n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL coll_play_empty got=%0d exp=0", state); end
    rec_req = 1'b1;
    step();
    rec_req = 1'b0;
    play_req = 1'b0;
    n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL coll_rec_wins got=%0d exp=1", state); end
    stop_req = 1'b1;
    step();
    stop_req = 1'b0;
    n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL coll_stop_state got=%0d exp=0", state); end
    n_checks++; if (rec_len !== 4'd0) begin n_fail++; $display("FAIL coll_stop_len got=%0d exp=0", rec_len); end
  endtask

  initial begin
    step();
    test_reset();
    test_play_empty();
    test_fill();
    test_playback();
    test_rec_during_play();
    test_stop_record();
    test_reset_mid_play();
    test_collision();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/audio_rec_ctrl.md
# audio_rec_ctrl

Record/playback sequencer for the FPGA audio recorder. It paces microphone samples into the sample memory at a fixed sample rate and replays them to the PWM output. It arbitrates the single memory port between record and play, so only one direction is ever active. It sits between the debounced button front-end, the microphone sample register and the block RAM.

## Interface
- DIV, 12500: clk cycles per sample tick (100 MHz / 8 kHz); must be >= 2.
- ADDR_W, 17: sample memory address width; depth = 2^ADDR_W.
- DATA_W, 8: sample width.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- rec_req  in  1  start recording; level, debounced.
- play_req  in  1  start playback; level, debounced.
- stop_req  in  1  abort the current operation.
- mic_sample  in  DATA_W  current microphone sample.
- mem_rdata  in  DATA_W  memory read data; synchronous read, 1-cycle latency.
- mem_addr  out  ADDR_W  memory address.
- mem_we  out  1  memory write strobe, one cycle per sample.
- mem_wdata  out  DATA_W  memory write data.
- play_sample  out  DATA_W  sample driven to the PWM stage.
- state  out  2  0 IDLE, 1 REC, 2 PLAY.
- rec_len  out  ADDR_W+1  number of valid recorded samples.

## Operation
- Reset: state IDLE. mem_addr, mem_we, mem_wdata, play_sample, rec_len and all internal counters are 0.
- Request priority: stop_req > rec_req > play_req. rec_req and play_req are acted on only in IDLE. stop_req in IDLE has no effect.
- IDLE -> REC on rec_req. Entry clears wr_ptr.
- IDLE -> PLAY on play_req, only if rec_len != 0. Entry clears rd_ptr.
- Tick counter:
  - Held at 0 in IDLE; cleared on entry to REC or PLAY.
  - Counts 0..DIV-1 and wraps.
  - tick = (count == DIV-1).
- REC:
  - mem_addr = wr_ptr.
  - On each tick: mem_we=1 and mem_wdata=mic_sample in that same cycle, then wr_ptr increments.
  - On the write to address 2^ADDR_W-1 (memory full): next state IDLE, rec_len = 2^ADDR_W.
  - On stop_req: next state IDLE, rec_len = wr_ptr (samples written so far). A tick coinciding with stop_req is not written.
- PLAY:
  - mem_addr = rd_ptr. mem_rdata is therefore stable well before each tick.
  - On each tick: play_sample <= mem_rdata, then rd_ptr increments.
  - After the tick that consumes index rec_len-1: next state IDLE, and play_sample holds its last value.
  - On stop_req: next state IDLE, play_sample holds.
- mem_we is 0 outside REC.
- A new recording overwrites memory from address 0. rec_len keeps its old value until the new recording ends.
- reset asserted mid-operation returns to the reset state on the next edge. rec_len is lost.

## Timing
- A request sampled high at edge N puts the block in its new state from edge N. The first tick falls DIV-1 cycles later.
- Sample period is exactly DIV cycles in REC and PLAY.
- mem_we is high for exactly one cycle per tick, coincident with tick.
- play_sample updates at the edge that ends the tick cycle.
- Return to IDLE occurs at the edge ending the final tick, or the edge at which stop_req is sampled.

## Configuration
- AUDIO_REC_LOOP_EN defined: PLAY does not end at rec_len-1. rd_ptr wraps to 0 and playback continues until stop_req.
- AUDIO_REC_LOOP_EN undefined: single-shot playback as described in Operation.

## Structure
- Shared package audio_rec_pkg holds:
  - the state enum (IDLE/REC/PLAY, 2 bits);
  - default constants for DIV, ADDR_W and DATA_W.
- One sub-module, sample_tick_gen: a parameterized DIV counter with clear and enable inputs and a tick output. It is reusable by the PWM stage.

## Test plan
All scenarios use DIV=4, ADDR_W=3, DATA_W=8.
- Reset: assert reset for 2 cycles -> state=0, mem_we=0, play_sample=0, rec_len=0.
- Fill recording: rec_req pulse, mic_sample = tick index (1..8) -> 8 mem_we pulses, 4 cycles apart, addr 0..7, data 1..8; then state=IDLE, rec_len=8.
- Stop mid-record: rec_req, then stop_req after the 3rd write -> rec_len=3, no further mem_we.
- Playback: after the fill, play_req -> play_sample steps 1..8 every 4 cycles, then state=IDLE and play_sample holds 8. With AUDIO_REC_LOOP_EN defined, the sequence wraps to 1 until stop_req.
- Request collisions:
  - play_req with rec_len=0 -> stays IDLE.
  - rec_req and play_req in the same cycle -> REC.
  - rec_req during PLAY -> ignored.
- Reset mid-PLAY -> next cycle state=0, rec_len=0, mem_we=0.
